o_sync_lock: RTL and testbench
==============================

O_SYNC_LOCK -- requirements
Module: o_sync_lock

Interface
REQ-001 Parameter H_TOTAL, default 800: expected clocks per line (HS edge to HS edge).
REQ-002 Parameter V_TOTAL, default 417: expected lines per frame (HS edges between VS edges).
REQ-003 Parameter H_TOL, default 4: allowed +/- deviation of line period, in clocks.
REQ-004 Parameter LOCK_FRAMES, default 4: consecutive good frames required to lock.
REQ-005 Parameter LOSS_FRAMES, default 2: consecutive bad frames tolerated before lock drop.
REQ-006 Parameter HS_POL / VS_POL, default 1'b0 / 1'b0: asserted level of O_HS / O_VS.
REQ-007 O_CLK  in  1: oscilloscope pixel clock; the only clock, all logic on rising edge.
REQ-008 RST  in  1: reset, synchronous, active-high.
REQ-009 O_HS  in  1: horizontal sync from oscilloscope.
REQ-010 O_VS  in  1: vertical sync from oscilloscope.
REQ-011 ENABLE  out  1: enable for the oscilloscope pixel counter; high only while locked.
REQ-012 LOCKED  out  1: high in LOCKED state only.
REQ-013 STATE  out  2: IDLE=0, ACQUIRE=1, LOCKED=2, HOLD=3.
REQ-014 MEAS_H  out  11: last measured line period, clocks.
REQ-015 MEAS_V  out  10: last measured lines per frame.
REQ-016 LOCK_LOST  out  1: one-cycle pulse when ENABLE falls.

Function
REQ-017 HS edge = O_HS == HS_POL and previous-cycle O_HS != HS_POL (one-cycle registered history); VS edge likewise with VS_POL.
REQ-018 Clock counter: 11 bits, +1 per cycle, saturates at 2047, cleared to 1 on HS edge; MEAS_H <= count value at HS edge.
REQ-019 Line counter: 10 bits, +1 per HS edge, saturates at 1023, cleared on VS edge; MEAS_V <= count at VS edge (including a same-cycle HS edge).
REQ-020 Line bad: MEAS_H candidate outside [H_TOTAL-H_TOL, H_TOTAL+H_TOL]; sets a sticky frame-bad flag, cleared on VS edge; first HS edge after a VS edge also evaluated.
REQ-021 Frame good at VS edge: frame-bad flag clear (incl. same-cycle line) and line count == V_TOTAL.
REQ-022 Simultaneous HS and VS edge: HS edge counted/evaluated into the ending frame, then frame evaluated.
REQ-023 Timeout: no HS edge for 2*H_TOTAL consecutive cycles -> IDLE from any state; timeout has priority over a same-cycle VS edge.
REQ-024 IDLE -> ACQUIRE on first VS edge (partial frame discarded); good-frame count = 0.
REQ-025 ACQUIRE: good frame -> count+1; on reaching LOCK_FRAMES -> LOCKED; bad frame -> count=0, stay.
REQ-026 LOCKED: bad frame -> HOLD, miss count = 1; good frame -> stay.
REQ-027 HOLD: good frame -> LOCKED, miss = 0; bad frame -> miss+1; miss reaching LOSS_FRAMES -> ACQUIRE, good count = 0.
REQ-028 ENABLE registered, high iff state is LOCKED or HOLD; rises/falls one cycle after the VS edge causing the transition (timeout: one cycle after timeout cycle).
REQ-029 LOCK_LOST high exactly the cycle ENABLE goes 1->0; LOCKED, STATE registered, same timing as ENABLE.

Reset
REQ-030 On RST: STATE=IDLE, ENABLE=0, LOCKED=0, LOCK_LOST=0, MEAS_H=0, MEAS_V=0, all counters/flags 0, sync history = deasserted level (no false edge next cycle).
REQ-031 RST mid-lock drops ENABLE next cycle without LOCK_LOST pulse; RST overrides all events.

Verification
REQ-032 Nominal 800x417 sync, HS/VS active-low -> ACQUIRE after 1st VS, LOCKED/ENABLE=1 one cycle after 5th VS edge; MEAS_H=800, MEAS_V=417.
REQ-033 Locked, one frame of 416 lines -> HOLD (STATE=3, ENABLE stays 1); next good frame -> LOCKED.
REQ-034 Locked, two consecutive frames with one 806-clock line -> ACQUIRE, ENABLE=0, LOCK_LOST one-cycle pulse.
REQ-035 Locked, HS stopped -> IDLE 1600 cycles after last HS edge, ENABLE=0, LOCK_LOST pulse.
REQ-036 Line period 804 (within tol) and HS/VS edges coincident -> still locks; MEAS_V counts coincident line.
REQ-037 RST asserted in LOCKED for 1 cycle -> all outputs reset next cycle, no LOCK_LOST, re-lock after 5 further VS edges.

Source files
------------

// File: rtl/o_sync_lock.sv
// Sync lock detector for the oscilloscope video input.
// Measures the HS line period and the lines per VS frame. Grades each frame
// as good or bad and runs an IDLE/ACQUIRE/LOCKED/HOLD state machine.
// The state machine drives ENABLE for the oscilloscope pixel counter.
module o_sync_lock #(
   parameter int   H_TOTAL     = 800,
   parameter int   V_TOTAL     = 417,
   parameter int   H_TOL       = 4,
   parameter int   LOCK_FRAMES = 4,
   parameter int   LOSS_FRAMES = 2,
   parameter logic HS_POL      = 1'b0,
   parameter logic VS_POL      = 1'b0
) (
   input  logic        O_CLK,
   input  logic        RST,
   input  logic        O_HS,
   input  logic        O_VS,
   output logic        ENABLE,
   output logic        LOCKED,
   output logic [1:0]  STATE,
   output logic [10:0] MEAS_H,
   output logic [9:0]  MEAS_V,
   output logic        LOCK_LOST
);

   localparam logic [10:0]   H_MIN     = 11'(H_TOTAL - H_TOL);
   localparam logic [10:0]   H_MAX     = 11'(H_TOTAL + H_TOL);
   localparam logic [9:0]    V_EXP     = 10'(V_TOTAL);
   localparam int            TO_LIM    = 2 * H_TOTAL;
   localparam int            TW        = $clog2(TO_LIM + 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TO_LIM);
   localparam int            GW        = $clog2(LOCK_FRAMES + 1);
   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);
   localparam int            MW        = $clog2(LOSS_FRAMES + 1);
   localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   logic          hs_q, vs_q;
   logic [10:0]   clk_cnt_q, clk_cnt_d;
   logic [9:0]    line_cnt_q, line_cnt_d;
   logic [TW-1:0] gap_q, gap_d;
   logic [10:0]   meas_h_q, meas_h_d;
   logic [9:0]    meas_v_q, meas_v_d;
   logic          frame_bad_q, frame_bad_d;
   state_t        state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic [MW-1:0] miss_q, miss_d;
   logic          enable_q, enable_d;
   logic          locked_q, locked_d;
   logic          lost_q, lost_d;

   logic          hs_edge, vs_edge, line_bad, frame_good, timeout;
   logic [9:0]    line_total;

   // Assertion edges are qualified against one cycle of registered history.
   assign hs_edge = (O_HS == HS_POL) && (hs_q != HS_POL);
   assign vs_edge = (O_VS == VS_POL) && (vs_q != VS_POL);

   // A line arriving in the same cycle as VS still belongs to the ending frame.
   assign line_total = (hs_edge && (line_cnt_q != 10'h3FF)) ? line_cnt_q + 10'd1 : line_cnt_q;
   assign line_bad   = hs_edge && ((clk_cnt_q < H_MIN) || (clk_cnt_q > H_MAX));
   assign frame_good = !frame_bad_q && !line_bad && (line_total == V_EXP);
   assign timeout    = !hs_edge && (gap_q == TO_MAX);

   // Line/frame measurement counters and the sticky bad-line flag.
   always_comb begin
      clk_cnt_d   = (clk_cnt_q == 11'h7FF) ? clk_cnt_q : clk_cnt_q + 11'd1;
      gap_d       = (gap_q == TO_MAX) ? gap_q : gap_q + TW'(1);
      line_cnt_d  = line_cnt_q;
      meas_h_d    = meas_h_q;
      meas_v_d    = meas_v_q;
      frame_bad_d = frame_bad_q | line_bad;
      if (hs_edge) begin
         clk_cnt_d  = 11'd1;
         gap_d      = TW'(1);
         meas_h_d   = clk_cnt_q;
         line_cnt_d = line_total;
      end
      if (vs_edge) begin
         line_cnt_d  = 10'd0;
         meas_v_d    = line_total;
         frame_bad_d = 1'b0;
      end
   end

   // Lock state machine; a loss of HS overrides any frame decision.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      miss_d  = miss_q;
      if (timeout) begin
         state_d = ST_IDLE;
         good_d  = '0;
         miss_d  = '0;
      end else if (vs_edge) begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQUIRE;
               good_d  = '0;
               miss_d  = '0;
            end
            ST_ACQUIRE: begin
               if (!frame_good) begin
                  good_d = '0;
               end else if (good_q == GOOD_LAST) begin
                  state_d = ST_LOCKED;
                  good_d  = '0;
               end else begin
                  good_d = good_q + GW'(1);
               end
            end
            ST_LOCKED: begin
               if (!frame_good) begin
                  state_d = ST_HOLD;
                  miss_d  = MW'(1);
               end
            end
            ST_HOLD: begin
               if (frame_good) begin
                  state_d = ST_LOCKED;
                  miss_d  = '0;
               end else if (miss_q == MISS_LAST) begin
                  state_d = ST_ACQUIRE;
                  good_d  = '0;
                  miss_d  = '0;
               end else begin
                  miss_d = miss_q + MW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      enable_d = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
      locked_d = (state_d == ST_LOCKED);
      lost_d   = enable_q && !enable_d;
   end

   // All state registers; reset parks sync history at the idle level.
   always_ff @(posedge O_CLK) begin
      if (RST) begin
         hs_q        <= ~HS_POL;
         vs_q        <= ~VS_POL;
         clk_cnt_q   <= '0;
         line_cnt_q  <= '0;
         gap_q       <= '0;
         meas_h_q    <= '0;
         meas_v_q    <= '0;
         frame_bad_q <= 1'b0;
         state_q     <= ST_IDLE;
         good_q      <= '0;
         miss_q      <= '0;
         enable_q    <= 1'b0;
         locked_q    <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         hs_q        <= O_HS;
         vs_q        <= O_VS;
         clk_cnt_q   <= clk_cnt_d;
         line_cnt_q  <= line_cnt_d;
         gap_q       <= gap_d;
         meas_h_q    <= meas_h_d;
         meas_v_q    <= meas_v_d;
         frame_bad_q <= frame_bad_d;
         state_q     <= state_d;
         good_q      <= good_d;
         miss_q      <= miss_d;
         enable_q    <= enable_d;
         locked_q    <= locked_d;
         lost_q      <= lost_d;
      end
   end

   assign ENABLE    = enable_q;
   assign LOCKED    = locked_q;
   assign STATE     = state_q;
   assign MEAS_H    = meas_h_q;
   assign MEAS_V    = meas_v_q;
   assign LOCK_LOST = lost_q;

endmodule

// File: tb/tb_o_sync_lock.sv
// Scoreboard bench for o_sync_lock using a scaled-down raster.
// The raster is 40 clocks per line and 12 lines per frame.
module tb_o_sync_lock;

   localparam int HT   = 40;
   localparam int VT   = 12;
   localparam int HTOL = 4;

   logic        clk = 1'b0;
   logic        rst, hs, vs;
   logic        enable, locked, lock_lost;
   logic [1:0]  state;
   logic [10:0] meas_h;
   logic [9:0]  meas_v;

   always #5 clk = ~clk;

   o_sync_lock #(
      .H_TOTAL    (HT),
      .V_TOTAL    (VT),
      .H_TOL      (HTOL),
      .LOCK_FRAMES(4),
      .LOSS_FRAMES(2),
      .HS_POL     (1'b0),
      .VS_POL     (1'b0)
   ) dut (
      .O_CLK    (clk),
      .RST      (rst),
      .O_HS     (hs),
      .O_VS     (vs),
      .ENABLE   (enable),
      .LOCKED   (locked),
      .STATE    (state),
      .MEAS_H   (meas_h),
      .MEAS_V   (meas_v),
      .LOCK_LOST(lock_lost)
   );

   typedef struct {
      int st;
      int en;
      int lk;
      int lost;
      int mh;
      int mv;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   err_cnt = 0;
   int   chk_cnt = 0;
   bit   vs_fire = 1'b0;

   task automatic check_eq(input string tag, input int act, input int exp);
      chk_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One line: HS asserted for 4 clocks at the start, optional VS.
   task automatic drive_line(input int period, input bit with_vs, input bit coinc);
      int vs_at;
      vs_at = coinc ? 0 : 10;
      for (int c = 0; c < period; c++) begin
         @(negedge clk);
         hs      = (c < 4) ? 1'b0 : 1'b1;
         vs      = (with_vs && c >= vs_at && c < vs_at + 8) ? 1'b0 : 1'b1;
         vs_fire = with_vs && (c == vs_at);
      end
   endtask

   task automatic lines(input int n, input int period);
      for (int i = 0; i < n; i++) drive_line(period, 1'b0, 1'b0);
   endtask

   task automatic frame_end(input int period, input bit coinc, input int st, input int en,
                            input int lk, input int lost, input int mh, input int mv);
      exp_t e;
      e.st = st; e.en = en; e.lk = lk; e.lost = lost; e.mh = mh; e.mv = mv;
      sb_q.push_back(e);
      drive_line(period, 1'b1, coinc);
   endtask

   // Four good frames from ACQUIRE with zero good count lead to LOCKED.
   task automatic lock_seq(input int period, input bit coinc);
      for (int i = 0; i < 4; i++) begin
         lines(VT - 1, period);
         frame_end(period, coinc, (i == 3) ? 2 : 1, (i == 3) ? 1 : 0,
                   (i == 3) ? 1 : 0, 0, period, VT);
      end
   endtask

   task automatic line_print(input string tag);
      $display("%s: state=%0d enable=%0d locked=%0d lost=%0d meas_h=%0d meas_v=%0d",
               tag, state, enable, locked, lock_lost, meas_h, meas_v);
   endtask

   // Monitor: after each VS edge, pop the expectation and compare outputs.
   always @(posedge clk) begin
      if (vs_fire) begin
         #1;
         check_eq("sb_pending", int'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            line_print("vs");
            check_eq("vs_state", int'(state), mon_e.st);
            check_eq("vs_enable", int'(enable), mon_e.en);
            check_eq("vs_locked", int'(locked), mon_e.lk);
            check_eq("vs_lost", int'(lock_lost), mon_e.lost);
            check_eq("vs_meas_h", int'(meas_h), mon_e.mh);
            if (mon_e.mv >= 0) check_eq("vs_meas_v", int'(meas_v), mon_e.mv);
         end
         @(posedge clk);
         #1;
         check_eq("vs_lost_after", int'(lock_lost), 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; hs = 1'b1; vs = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      line_print("reset");
      check_eq("rst_state", int'(state), 0);
      check_eq("rst_enable", int'(enable), 0);
      check_eq("rst_locked", int'(locked), 0);
      check_eq("rst_lost", int'(lock_lost), 0);
      check_eq("rst_meas_h", int'(meas_h), 0);
      check_eq("rst_meas_v", int'(meas_v), 0);
      @(negedge clk) rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("idle_meas_h", int'(meas_h), 0);
      check_eq("idle_state", int'(state), 0);

      // Nominal raster: ACQUIRE after first VS, LOCKED after the fifth.
      lines(3, HT);
      frame_end(HT, 1'b0, 1, 0, 0, 0, HT, 4);
      lock_seq(HT, 1'b0);

      // One short frame goes to HOLD, the next good frame recovers.
      lines(VT - 2, HT);
      frame_end(HT, 1'b0, 3, 1, 0, 0, HT, VT - 1);
      lines(VT - 1, HT);
      frame_end(HT, 1'b0, 2, 1, 1, 0, HT, VT);

      // Two frames each with one line just outside tolerance drop the lock.
      for (int i = 0; i < 2; i++) begin
         lines(5, HT);
         lines(1, HT + HTOL + 2);
         lines(VT - 7, HT);
         frame_end(HT, 1'b0, (i == 0) ? 3 : 1, (i == 0) ? 1 : 0, 0, (i == 0) ? 0 : 1, HT, VT);
      end
      lock_seq(HT, 1'b0);

      // HS stops: lock drops 2*HT cycles after the last HS edge.
      lines(2, HT);
      @(negedge clk); hs = 1'b0; vs = 1'b1;
      @(posedge clk);
      @(negedge clk); hs = 1'b1;
      repeat (2 * HT - 1) @(posedge clk);
      #1;
      line_print("pre_timeout");
      check_eq("to_pre_state", int'(state), 2);
      check_eq("to_pre_enable", int'(enable), 1);
      @(posedge clk);
      #1;
      line_print("timeout");
      check_eq("to_state", int'(state), 0);
      check_eq("to_enable", int'(enable), 0);
      check_eq("to_locked", int'(locked), 0);
      check_eq("to_lost", int'(lock_lost), 1);
      @(posedge clk);
      #1;
      check_eq("to_lost_after", int'(lock_lost), 0);

      // Line period at the tolerance limit with HS/VS coincident still locks.
      lines(3, HT + HTOL);
      frame_end(HT + HTOL, 1'b1, 1, 0, 0, 0, HT + HTOL, -1);
      lock_seq(HT + HTOL, 1'b1);

      // One-cycle reset while locked clears everything without a loss pulse.
      lines(2, HT + HTOL);
      @(negedge clk); rst = 1'b1; hs = 1'b1; vs = 1'b1;
      @(posedge clk);
      #1;
      line_print("mid_reset");
      check_eq("mr_state", int'(state), 0);
      check_eq("mr_enable", int'(enable), 0);
      check_eq("mr_locked", int'(locked), 0);
      check_eq("mr_lost", int'(lock_lost), 0);
      check_eq("mr_meas_h", int'(meas_h), 0);
      check_eq("mr_meas_v", int'(meas_v), 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("mr_lost_after", int'(lock_lost), 0);
      check_eq("mr_enable_after", int'(enable), 0);
      lines(3, HT);
      frame_end(HT, 1'b0, 1, 0, 0, 0, HT, 4);
      lock_seq(HT, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check_eq("sb_drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
